// File: rtl/dla_buf_mask_seq.sv
// Buffer-mask walker: snapshots the staged mask on start and issues each
// non-empty lane group, lowest index first, over a valid/ready handshake.
module dla_buf_mask_seq #(
  parameter int unsigned GRP_NUM = 16,
  parameter int unsigned GRP_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [GRP_NUM*GRP_W-1:0]      buf_mask,
  output logic                          busy,
  output logic                          grp_valid,
  input  logic                          grp_ready,
  output logic [$clog2(GRP_NUM)-1:0]    grp_idx,
  output logic [GRP_W-1:0]              grp_mask,
  output logic                          grp_last,
  output logic [$clog2(GRP_NUM+1)-1:0]  grp_count,
  output logic                          done
);

  localparam int unsigned MASK_W = GRP_NUM * GRP_W;
  localparam int unsigned IDX_W  = $clog2(GRP_NUM);
  localparam int unsigned CNT_W  = $clog2(GRP_NUM + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [MASK_W-1:0]  snap_q, snap_d;
  logic [GRP_NUM-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GRP_NUM-1:0] pend_init;
  logic [IDX_W-1:0]   idx_c;
  logic [GRP_W-1:0]   mask_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // One pending bit per group that has at least one lane set
  always_comb begin
    pend_init = '0;
    for (int g = 0; g < int'(GRP_NUM); g++) begin
      pend_init[g] = |buf_mask[g*GRP_W +: GRP_W];
    end
  end

  // Priority pick of the lowest pending group from registered state only
  always_comb begin
    idx_c  = '0;
    mask_c = snap_q[GRP_W-1:0];
    for (int g = int'(GRP_NUM) - 1; g >= 0; g--) begin
      if (pend_q[g]) begin
        idx_c  = IDX_W'(g);
        mask_c = snap_q[g*GRP_W +: GRP_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = buf_mask;
          pend_d  = pend_init;
          cnt_d   = '0;
          state_d = (pend_init != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (grp_ready) begin
          pend_d[idx_c] = 1'b0;
          cnt_d         = cnt_q + CNT_W'(1);
          if (grp_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign grp_valid = (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE);
  assign grp_idx   = idx_c;
  assign grp_mask  = mask_c;
  assign grp_last  = (pend_q != '0) && ((pend_q & (pend_q - GRP_NUM'(1))) == '0);
  assign grp_count = cnt_q;

endmodule

// File: tb/tb_dla_buf_mask_seq.sv
// Randomized self-checking bench for dla_buf_mask_seq against a queue-based
// model of the expected group sequence.
module tb_dla_buf_mask_seq;

  localparam int unsigned GRP_NUM = 16;
  localparam int unsigned GRP_W   = 16;
  localparam int unsigned MASK_W  = GRP_NUM * GRP_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [MASK_W-1:0] buf_mask;
  logic              busy;
  logic              grp_valid;
  logic              grp_ready;
  logic [3:0]        grp_idx;
  logic [15:0]       grp_mask;
  logic              grp_last;
  logic [4:0]        grp_count;
  logic              done;

  int errors = 0;
  int checks = 0;

  dla_buf_mask_seq #(.GRP_NUM(GRP_NUM), .GRP_W(GRP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .buf_mask(buf_mask), .busy(busy),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_idx(grp_idx),
    .grp_mask(grp_mask), .grp_last(grp_last), .grp_count(grp_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name, input int want_cnt);
    checks++;
    if (busy !== 1'b0 || grp_valid !== 1'b0 || done !== 1'b0 || grp_count !== 5'(want_cnt)) begin
      errors++;
      $display("FAIL %s idle: busy=%0b valid=%0b done=%0b count=%0d want 0/0/0/%0d",
               name, busy, grp_valid, done, grp_count, want_cnt);
    end
  endtask

  // Runs one walk: stall = forced not-ready cycles first, disturb = scramble
  // buf_mask/start mid-walk, abort_at = accepted count at which rst fires (-1 none)
  task automatic run_walk(input logic [MASK_W-1:0] m, input int ready_pct, input int stall,
                          input bit disturb, input int abort_at, input string name);
    int q_idx[$];
    logic [15:0] q_mask[$];
    int total, acc, cyc;
    logic rdy;
    logic [15:0] slice;
    for (int g = 0; g < int'(GRP_NUM); g++) begin
      slice = m[g*GRP_W +: GRP_W];
      if (slice != 16'h0) begin
        q_idx.push_back(g);
        q_mask.push_back(slice);
      end
    end
    total = q_idx.size();
    acc = 0;
    cyc = 0;
    buf_mask  = m;
    start     = 1'b1;
    grp_ready = 1'($urandom);
    step();
    start = 1'b0;
    if (disturb) buf_mask = '0;
    while (q_idx.size() > 0 && cyc < 2000) begin
      checks++;
      if (grp_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s ctl cyc%0d: valid=%0b busy=%0b done=%0b want 1/1/0",
                 name, cyc, grp_valid, busy, done);
      end
      checks++;
      if (grp_idx !== 4'(q_idx[0]) || grp_mask !== q_mask[0]) begin
        errors++;
        $display("FAIL %s desc cyc%0d: idx=%0d mask=%h want idx=%0d mask=%h",
                 name, cyc, grp_idx, grp_mask, q_idx[0], q_mask[0]);
      end
      checks++;
      if (grp_last !== (q_idx.size() == 1) || grp_count !== 5'(acc)) begin
        errors++;
        $display("FAIL %s last/count cyc%0d: last=%0b count=%0d want %0b/%0d",
                 name, cyc, grp_last, grp_count, q_idx.size() == 1, acc);
      end
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || grp_valid !== 1'b0 || grp_count !== 5'd0 || done !== 1'b0 ||
            grp_idx !== 4'd0 || grp_mask !== 16'h0 || grp_last !== 1'b0) begin
          errors++;
          $display("FAIL %s abort: busy=%0b valid=%0b count=%0d done=%0b idx=%0d mask=%h last=%0b want all 0",
                   name, busy, grp_valid, grp_count, done, grp_idx, grp_mask, grp_last);
        end
        for (int i = 0; i < 4; i++) begin
          step();
          check_idle_outputs({name, " post-abort"}, 0);
        end
        return;
      end
      rdy = (cyc < stall) ? 1'b0 : (int'($urandom_range(0, 99)) < ready_pct);
      grp_ready = rdy;
      if (disturb) begin
        start = 1'($urandom);
        buf_mask = {8{$urandom}};
      end
      step();
      if (rdy) begin
        void'(q_idx.pop_front());
        void'(q_mask.pop_front());
        acc++;
      end
      cyc++;
    end
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL %s timeout: %0d groups still expected", name, q_idx.size());
    end
    if (ready_pct == 100 && stall == 0) begin
      checks++;
      if (cyc != total) begin
        errors++;
        $display("FAIL %s throughput: took %0d cycles want %0d", name, cyc, total);
      end
    end
    start = disturb ? 1'b1 : 1'b0;
    grp_ready = 1'($urandom);
    checks++;
    if (done !== 1'b1 || grp_valid !== 1'b0 || busy !== 1'b1 || grp_count !== 5'(total)) begin
      errors++;
      $display("FAIL %s done: done=%0b valid=%0b busy=%0b count=%0d want 1/0/1/%0d",
               name, done, grp_valid, busy, grp_count, total);
    end
    step();
    start = 1'b0;
    check_idle_outputs({name, " after-done"}, total);
    step();
    check_idle_outputs({name, " hold"}, total);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; grp_ready = 1'b0; buf_mask = '0;
    step(); step();
    checks++;
    if (busy !== 1'b0 || grp_valid !== 1'b0 || grp_idx !== 4'd0 || grp_mask !== 16'h0 ||
        grp_last !== 1'b0 || grp_count !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%0b valid=%0b idx=%0d mask=%h last=%0b count=%0d done=%0b want all 0",
               busy, grp_valid, grp_idx, grp_mask, grp_last, grp_count, done);
    end
    rst = 1'b0;
    step();
    check_idle_outputs("reset idle", 0);
  endtask

  task automatic test_all_ones();
    run_walk({MASK_W{1'b1}}, 100, 0, 1'b0, -1, "all_ones");
  endtask

  task automatic test_sparse();
    logic [MASK_W-1:0] m = '0;
    m[3*GRP_W +: GRP_W]  = 16'h00F0;
    m[12*GRP_W +: GRP_W] = 16'h8001;
    run_walk(m, 100, 0, 1'b0, -1, "sparse");
  endtask

  task automatic test_zero();
    run_walk('0, 100, 0, 1'b0, -1, "zero");
  endtask

  task automatic test_backpressure();
    logic [MASK_W-1:0] m = '0;
    m[0 +: GRP_W]     = 16'h1234;
    m[GRP_W +: GRP_W] = 16'h0008;
    run_walk(m, 100, 5, 1'b0, -1, "backpressure");
  endtask

  task automatic test_mask_change();
    logic [MASK_W-1:0] m = '0;
    m[1*GRP_W +: GRP_W]  = 16'hA5A5;
    m[4*GRP_W +: GRP_W]  = 16'h0001;
    m[9*GRP_W +: GRP_W]  = 16'h8000;
    m[15*GRP_W +: GRP_W] = 16'h0F0F;
    run_walk(m, 70, 0, 1'b1, -1, "mask_change");
  endtask

  task automatic test_reset_mid();
    logic [MASK_W-1:0] m = '0;
    for (int g = 2; g < 12; g++) m[g*GRP_W +: GRP_W] = 16'(g * 16'h0111);
    run_walk(m, 100, 0, 1'b0, 4, "reset_mid");
    run_walk(m, 100, 0, 1'b0, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [MASK_W-1:0] m;
    logic [15:0] v;
    for (int t = 0; t < 25; t++) begin
      m = '0;
      for (int g = 0; g < int'(GRP_NUM); g++) begin
        v = 16'($urandom);
        if (v == 16'h0) v = 16'h0001;
        if ($urandom_range(0, 1) == 1) m[g*GRP_W +: GRP_W] = v;
      end
      run_walk(m, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)),
               1'($urandom), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_sparse();
    test_zero();
    test_backpressure();
    test_mask_change();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
